// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU; single-cycle logic ops, shift-add MUL and restoring DIV.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [7:0]       flags
);

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_LT   = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic               gt_q;
  logic [WIDTH-1:0]   out_q, out_hi_q;
  logic [7:0]         flags_q;

  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [WIDTH:0]     add_s, sub_s, mul_sum, div_r;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   res_out, res_hi;
  logic [7:0]         res_flags;

  // Results of the ops that complete on the accepting edge.
  always_comb begin
    add_s     = {1'b0, A} + {1'b0, B};
    sub_s     = {1'b0, A} - {1'b0, B};
    res_out   = '0;
    res_hi    = '0;
    res_flags = '0;
    case (control)
      OP_PASS: res_out = B;
      OP_AND:  res_out = A & B;
      OP_ADD: begin
        res_out      = add_s[WIDTH-1:0];
        res_flags[0] = add_s[WIDTH];
        res_flags[3] = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_out      = sub_s[WIDTH-1:0];
        res_flags[0] = sub_s[WIDTH];
        res_flags[3] = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   res_out = A | B;
      OP_NOT:  res_out = ~A;
      OP_SHL: begin
        res_out      = {A[WIDTH-2:0], 1'b0};
        res_flags[0] = A[WIDTH-1];
      end
      OP_SHR: begin
        res_out      = {1'b0, A[WIDTH-1:1]};
        res_flags[0] = A[0];
      end
      OP_LT:   res_out = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MUL:  res_out = '0;
      OP_DIV: begin
        // Only reaches the output path when B is zero.
        res_out      = '1;
        res_hi       = A;
        res_flags[4] = 1'b1;
      end
      default: res_flags[5] = 1'b1;
    endcase
    res_flags[1] = (res_out == '0);
    res_flags[2] = (A > B);
  end

  // One MUL/DIV step: hi holds partial product / remainder, lo holds multiplier / quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, b_q});
    div_sub = div_r[WIDTH-1:0] - b_q;
    if (state_q == DIV) begin
      hi_d = div_ge ? div_sub : div_r[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      gt_q     <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            hi_q  <= '0;
            lo_q  <= A;
            b_q   <= B;
            gt_q  <= (A > B);
            cnt_q <= CNT_W'(WIDTH);
            if (control == OP_MUL) begin
              state_q <= MUL;
            end else if ((control == OP_DIV) && (B != '0)) begin
              state_q <= DIV;
            end else begin
              state_q  <= DONE;
              out_q    <= res_out;
              out_hi_q <= res_hi;
              flags_q  <= res_flags;
            end
          end
        end
        MUL, DIV: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= DONE;
            out_q    <= lo_d;
            out_hi_q <= hi_d;
            flags_q  <= {5'b0, gt_q, (lo_d == '0), (state_q == MUL) && (hi_d != '0)};
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random + directed stimulus against a behavioural model, scoreboard-checked.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_alu_seq;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0]  A = '0, B = '0, out, out_hi;
  logic [3:0]    control = '0;
  logic [7:0]    flags;

  logic          in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [W2-1:0] A2 = '0, B2 = '0, out2, out_hi2;
  logic [3:0]    control2 = '0;
  logic [7:0]    flags2;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .flags(flags)
  );

  alu_seq #(.WIDTH(W2), .CNT_W(6)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(A2), .B(B2), .control(control2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out(out2), .out_hi(out_hi2), .flags(flags2)
  );

  typedef struct {
    logic [31:0] o;
    logic [31:0] h;
    logic [7:0]  f;
    int          issue;
    int          lat;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0;
  bit         seen = 1'b0, stall = 1'b0, rnd_ready = 1'b0;
  logic [W-1:0] hold_o, hold_h;
  logic [7:0]   hold_f;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(longint unsigned a, longint unsigned b, int op, int w);
    exp_t e;
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned r = 0, h = 0, p;
    longint half = 64'sd1 <<< (w - 1);
    longint sa, sb, ss;
    logic [7:0] f = '0;
    sa = (a >= half) ? longint'(a) - 2 * half : longint'(a);
    sb = (b >= half) ? longint'(b) - 2 * half : longint'(b);
    case (op)
      0: r = b;
      1: r = a & b;
      2: begin r = (a + b) & m; f[0] = ((a + b) > m); ss = sa + sb; f[3] = (ss >= half) || (ss < -half); end
      3: begin r = (a - b) & m; f[0] = (a < b); ss = sa - sb; f[3] = (ss >= half) || (ss < -half); end
      4: r = a | b;
      5: r = ~a & m;
      6: begin r = (a << 1) & m; f[0] = ((a >> (w - 1)) & 1) != 0; end
      7: begin r = a >> 1; f[0] = (a & 1) != 0; end
      8: r = (a < b) ? 1 : 0;
      9: begin p = a * b; r = p & m; h = p >> w; f[0] = (h != 0); end
      10: begin
        if (b == 0) begin r = m; h = a; f[4] = 1'b1; end
        else begin r = a / b; h = a % b; end
      end
      default: f[5] = 1'b1;
    endcase
    f[1] = (r == 0);
    f[2] = (a > b);
    e.o = r[31:0];
    e.h = h[31:0];
    e.f = f;
    e.issue = 0;
    e.lat = (op == 9 || (op == 10 && b != 0)) ? w + 1 : 1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    out_ready = stall ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: samples after all inputs for the coming edge have settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", cyc - sbq[0].issue, sbq[0].lat - 1);
          hold_o = out; hold_h = out_hi; hold_f = flags;
        end else begin
          check("hold_out", out, hold_o);
          check("hold_out_hi", out_hi, hold_h);
          check("hold_flags", flags, hold_f);
        end
        check("in_ready_when_done", in_ready, 0);
        if (out_ready) begin
          check("out", out, sbq[0].o);
          check("out_hi", out_hi, sbq[0].h);
          check("flags", flags, sbq[0].f);
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk); #1;
    while (!in_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin check("issue_timeout", in_ready, 1); return; end
    in_valid = 1'b1; A = a; B = b; control = op;
    if (push) begin
      e = model(a, b, op, W);
      e.issue = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; A = W'($urandom); B = W'($urandom); control = 4'($urandom);
  endtask

  task automatic junk(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      if (!in_ready) begin
        in_valid = 1'b1; A = W'($urandom); B = W'($urandom); control = 4'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); n++; end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e16;
    int iss, n;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk); #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_hi", out_hi, 0);
    check("rst_flags", flags, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(4'b0010, 8'hFF, 8'h01, 1);
    issue(4'b0011, 8'h80, 8'h01, 1);
    issue(4'b1001, 8'hFF, 8'hFF, 1);
    junk(12);
    issue(4'b1010, 8'd100, 8'd7, 1);
    issue(4'b1010, 8'd100, 8'd0, 1);
    issue(4'b0110, 8'h81, 8'h00, 1);
    issue(4'b0111, 8'h81, 8'h00, 1);
    issue(4'b1000, 8'h03, 8'h05, 1);
    issue(4'b0010, 8'h7F, 8'h01, 1);
    issue(4'b1100, 8'h12, 8'h34, 1);
    drain();

    stall = 1'b1;
    issue(4'b0000, 8'h5A, 8'h3C, 1);
    repeat (7) @(negedge clk);
    #2 check("stall_out_valid", out_valid, 1);
    stall = 1'b0;
    drain();

    rnd_ready = 1'b1;
    repeat (150) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      issue(4'($urandom_range(0, 15)), ra, rb, 1);
    end
    rnd_ready = 1'b0;
    drain();

    issue(4'b1001, 8'hAB, 8'hCD, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out", out, 0);
    check("abort_out_hi", out_hi, 0);
    check("abort_flags", flags, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    @(negedge clk); #1;
    in_valid2 = 1'b1; A2 = 16'h1234; B2 = 16'h0010; control2 = 4'b1001;
    iss = cyc + 1;
    e16 = model(64'h1234, 64'h0010, 9, W2);
    @(posedge clk); #1;
    in_valid2 = 1'b0; A2 = W2'($urandom); B2 = W2'($urandom);
    n = 0;
    @(negedge clk); #2;
    while (!out_valid2 && n < 100) begin @(negedge clk); #2; n++; end
    check("w16_latency", cyc - iss, e16.lat - 1);
    check("w16_out", out2, e16.o);
    check("w16_out_hi", out_hi2, e16.h);
    check("w16_flags", flags2, e16.f);
    out_ready2 = 1'b1;
    @(negedge clk); #2;
    check("w16_release", out_valid2, 0);

    issue(4'b0010, 8'h40, 8'h40, 1);
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
